// File: rtl/alu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// alu_seq_ctrl
//
// Purpose:
//   This block sequences a small 4-bit accumulator ALU. It accepts one
//   instruction at a time through a valid/ready handshake. It drives the ALU
//   operand, load and routing controls for one SETUP cycle and one EXEC
//   cycle, and then signals completion in a DONE cycle. In DONE it also
//   captures the ALU flags for arithmetic and logic operations.
//
//   Opcodes: 000 NOP, 001 LDA, 010 ADD, 011 AND, 100 OR, 101 XOR,
//            110 OUT, 111 illegal.
//
// Ports:
//   clk        in   1   rising-edge clock
//   rst        in   1   synchronous active-high reset
//   in_valid   in   1   instruction offered
//   in_ready   out  1   block accepts an instruction (IDLE only)
//   in_op      in   3   opcode
//   in_data    in   4   operand
//   flgs       in   3   ALU flags {carry, parity, zero}
//   tin        out  4   ALU operand
//   pin        out  4   accumulator load data
//   cmode      out  2   ALU op select: 00 add, 01 and, 10 or, 11 xor
//   uacc       out  1   accumulator / flag update enable
//   inmode     out  1   accumulator source (1 = pin)
//   outmode    out  1   accumulator routing (0 = bus, 1 = ALU)
//   done       out  1   one-cycle completion pulse
//   err        out  1   one-cycle illegal-opcode pulse
//   bus_valid  out  1   ALU bus carries the accumulator this cycle
//   flag_q     out  3   flags captured at the last ALU operation
//   op_cnt     out  CNT_W  completed-operation counter (optional)
//
// Configuration:
//   ALU_SEQ_OPCNT_EN  When this macro is defined, the block adds the op_cnt
//                     output. It is a saturating count of the completed
//                     LDA/ADD/AND/OR/XOR/OUT instructions. When the macro is
//                     undefined, the port and the counter are absent.
// ---------------------------------------------------------------------------
module alu_seq_ctrl #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [3:0]       in_data,
    input  logic [2:0]       flgs,
    output logic [3:0]       tin,
    output logic [3:0]       pin,
    output logic [1:0]       cmode,
    output logic             uacc,
    output logic             inmode,
    output logic             outmode,
    output logic             done,
    output logic             err,
    output logic             bus_valid,
    output logic [2:0]       flag_q
`ifdef ALU_SEQ_OPCNT_EN
    ,
    output logic [CNT_W-1:0] op_cnt
`endif
);

    // This generate condition is only a sanity hook on the counter width.
    // It does nothing for legal widths, and it keeps CNT_W referenced in the
    // build that has no counter.
    if (CNT_W < 1) begin : g_cnt_w_invalid
    end

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_LDA = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_OUT = 3'b110;
    localparam logic [2:0] OP_ILL = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SETUP = 2'b01,
        EXEC  = 2'b10,
        DONE  = 2'b11
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [2:0] op_q;
    logic [3:0] data_q;
    logic       accept;
    logic       in_is_long;
    logic       op_is_alu;
    logic       op_writes_acc;

    assign in_ready = (state == IDLE);
    assign accept   = in_valid && in_ready;

    // NOP and illegal opcodes skip SETUP and EXEC and go straight to DONE.
    // Every other opcode takes the full three-step path.
    assign in_is_long = (in_op != OP_NOP) && (in_op != OP_ILL);

    assign op_is_alu     = (op_q == OP_ADD) || (op_q == OP_AND) ||
                           (op_q == OP_OR)  || (op_q == OP_XOR);
    assign op_writes_acc = op_is_alu || (op_q == OP_LDA);

    // State, instruction and flag registers.
    // The instruction is captured only on a handshake, so the outputs do not
    // follow in_op/in_data once the instruction is accepted. Reset takes
    // priority over a handshake in the same cycle. Reset also drops any
    // in-flight instruction without a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            op_q   <= OP_NOP;
            data_q <= 4'd0;
            flag_q <= 3'b000;
        end else begin
            state <= state_next;
            if (accept) begin
                op_q   <= in_op;
                data_q <= in_data;
            end
            if ((state == DONE) && op_is_alu) begin
                flag_q <= flgs;
            end
        end
    end

    // Next-state logic.
    // IDLE is the only state that can accept an instruction. SETUP, EXEC and
    // DONE each last exactly one cycle. So a long instruction occupies four
    // cycles, including the accept cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = in_is_long ? SETUP : DONE;
                end
            end
            SETUP:   state_next = EXEC;
            EXEC:    state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode.
    // The operand and mode controls are held steady across SETUP and EXEC.
    // This lets the ALU settle before the single uacc strobe in EXEC. In IDLE
    // and DONE the controls return to the neutral values: routing to the
    // ALU, no load, and zero operands.
    always_comb begin
        tin       = 4'd0;
        pin       = 4'd0;
        cmode     = 2'b00;
        uacc      = 1'b0;
        inmode    = 1'b0;
        outmode   = 1'b1;
        done      = 1'b0;
        err       = 1'b0;
        bus_valid = 1'b0;

        case (state)
            SETUP, EXEC: begin
                case (op_q)
                    OP_LDA: begin
                        inmode = 1'b1;
                        pin    = data_q;
                    end
                    OP_ADD: begin
                        tin   = data_q;
                        cmode = 2'b00;
                    end
                    OP_AND: begin
                        tin   = data_q;
                        cmode = 2'b01;
                    end
                    OP_OR: begin
                        tin   = data_q;
                        cmode = 2'b10;
                    end
                    OP_XOR: begin
                        tin   = data_q;
                        cmode = 2'b11;
                    end
                    OP_OUT: begin
                        // The accumulator is routed to the bus for both
                        // cycles. The bus is only declared valid in EXEC,
                        // after the routing has been stable for a cycle.
                        outmode   = 1'b0;
                        bus_valid = (state == EXEC);
                    end
                    default: begin
                    end
                endcase
                uacc = (state == EXEC) && op_writes_acc;
            end
            DONE: begin
                done = 1'b1;
                err  = (op_q == OP_ILL);
            end
            default: begin
            end
        endcase
    end

`ifdef ALU_SEQ_OPCNT_EN
    // Completed-operation counter.
    // It counts DONE cycles of real work only, so NOP and illegal opcodes are
    // not counted. It holds at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_cnt <= '0;
        end else if ((state == DONE) && (op_q != OP_NOP) && (op_q != OP_ILL)
                     && (op_cnt != {CNT_W{1'b1}})) begin
            op_cnt <= op_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_seq_ctrl
//
// Scoreboard testbench for alu_seq_ctrl.
// - The stimulus process issues instructions. For each accepted instruction
//   it pushes a record onto the scoreboard queue. The record holds the
//   expected flags, which come from a reference accumulator model.
// - A separate monitor runs on every falling edge. It derives the expected
//   DUT outputs from the oldest in-flight record and from how many cycles
//   have passed since that record was accepted.
// - A small behavioural ALU closes the loop. It drives flgs from the
//   controls that the DUT produces.
// ---------------------------------------------------------------------------
module tb_alu_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] in_op = 3'd0;
    logic [3:0] in_data = 4'd0;
    logic [2:0] flgs;
    logic [3:0] tin;
    logic [3:0] pin;
    logic [1:0] cmode;
    logic       uacc;
    logic       inmode;
    logic       outmode;
    logic       done;
    logic       err;
    logic       bus_valid;
    logic [2:0] flag_q;
`ifdef ALU_SEQ_OPCNT_EN
    logic [7:0] op_cnt;
`endif

    typedef struct {
        logic [2:0] op;
        logic [3:0] data;
        int         acc;
        logic [2:0] fq;
    } txn_t;

    txn_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         model_acc = 0;
    int         last_acc = 0;
    logic [2:0] last_op = 3'd0;
    bit         last_keep = 1'b0;

    alu_seq_ctrl #(.CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_data   (in_data),
        .flgs      (flgs),
        .tin       (tin),
        .pin       (pin),
        .cmode     (cmode),
        .uacc      (uacc),
        .inmode    (inmode),
        .outmode   (outmode),
        .done      (done),
        .err       (err),
        .bus_valid (bus_valid),
        .flag_q    (flag_q)
`ifdef ALU_SEQ_OPCNT_EN
        ,
        .op_cnt    (op_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALU that sits next to the sequencer.
    // On uacc it updates its accumulator and flags {carry, even parity, zero}.
    // The accumulator is loaded from pin when inmode is 1. Otherwise the
    // accumulator is combined with tin according to cmode.
    logic [3:0] alu_acc;
    logic [2:0] alu_flg;
    logic [4:0] alu_next;

    always_comb begin
        alu_next = {1'b0, pin};
        if (!inmode) begin
            case (cmode)
                2'b00:   alu_next = {1'b0, alu_acc} + {1'b0, tin};
                2'b01:   alu_next = {1'b0, alu_acc & tin};
                2'b10:   alu_next = {1'b0, alu_acc | tin};
                default: alu_next = {1'b0, alu_acc ^ tin};
            endcase
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            alu_acc <= 4'd0;
            alu_flg <= 3'b000;
        end else if (uacc) begin
            alu_acc <= alu_next[3:0];
            alu_flg <= {alu_next[4], ~^alu_next[3:0], alu_next[3:0] == 4'd0};
        end
    end

    assign flgs = alu_flg;

    function automatic bit isLong(input logic [2:0] op);
        return (op != 3'd0) && (op != 3'd7);
    endfunction

    function automatic bit isAlu(input logic [2:0] op);
        return (op >= 3'd2) && (op <= 3'd5);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, expv);
        end
    endtask

    // Reference model at the instruction level. It updates the model
    // accumulator and returns the flags that an ADD/AND/OR/XOR would leave
    // behind.
    task automatic refStep(input logic [2:0] op, input logic [3:0] data,
                           output logic [2:0] fq);
        int r;
        bit c;
        c = 1'b0;
        case (op)
            3'd1: r = int'(data);
            3'd2: begin
                r = model_acc + int'(data);
                c = (r > 15);
                r = r % 16;
            end
            3'd3: r = model_acc & int'(data);
            3'd4: r = model_acc | int'(data);
            3'd5: r = model_acc ^ int'(data);
            default: r = model_acc;
        endcase
        model_acc = r;
        fq = {c, ($countones(4'(r)) % 2) == 0, r == 0};
    endtask

    // Offers one instruction and waits, with a bound, for the handshake.
    // After acceptance the inputs are scrambled. in_valid stays high only if
    // keep_valid is set, and in that case the next call must follow
    // immediately.
    task automatic applyStimulus(input logic [2:0] op, input logic [3:0] data,
                                 input bit keep_valid);
        bit   got;
        bit   rdy;
        bit   r;
        int   n;
        txn_t tr;
        got = 1'b0;
        n = 0;
        in_valid = 1'b1;
        in_op = op;
        in_data = data;
        while (!got && n < 16) begin
            @(negedge clk);
            rdy = in_ready;
            r = rst;
            @(posedge clk);
            #1;
            if (rdy && !r) got = 1'b1;
            n++;
        end
        checkOutput("accept within bound", 32'(got), 32'd1);
        if (!got) begin
            in_valid = 1'b0;
            last_keep = 1'b0;
            return;
        end
        tr.acc = cyc - 1;
        if (last_keep)
            checkOutput("accept spacing", 32'(tr.acc - last_acc),
                        isLong(last_op) ? 32'd4 : 32'd2);
        tr.op = op;
        tr.data = data;
        refStep(op, data, tr.fq);
        exp_q.push_back(tr);
        last_acc = tr.acc;
        last_op = op;
        last_keep = keep_valid;
        in_op = 3'($urandom);
        in_data = 4'($urandom);
        in_valid = keep_valid;
    endtask

    // Pulses rst for one cycle, k cycles after the return from
    // applyStimulus. An instruction is offered during the reset cycle to
    // confirm that reset blocks the handshake.
    task automatic resetAfter(input int k);
        if (k > 0) begin
            repeat (k) @(posedge clk);
            #1;
        end
        rst = 1'b1;
        in_valid = 1'b1;
        in_op = 3'($urandom_range(1, 6));
        in_data = 4'($urandom);
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        model_acc = 0;
        last_keep = 1'b0;
    endtask

    task automatic waitIdle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = (exp_q.size() == 0) && (in_ready === 1'b1);
        end
        @(posedge clk);
        #1;
        checkOutput("idle within bound", 32'(ok), 32'd1);
    endtask

    // Monitor / scoreboard.
    // The expected output vector depends only on the oldest in-flight
    // instruction and its age d (d = 0 is the handshake cycle). Long ops are
    // in SETUP at d=1 and EXEC at d=2, and complete at d=3. NOP and illegal
    // opcodes complete at d=1.
    txn_t        m_tr;
    int          m_d;
    int          m_lat;
    bit          m_pop;
    logic [19:0] m_exp;
    logic [19:0] m_act;
    logic [2:0]  fq_exp = 3'b000;
    int          cnt_exp = 0;

    always @(negedge clk) begin
        logic       e_rdy, e_uacc, e_inm, e_outm, e_done, e_err, e_bus;
        logic [1:0] e_cm;
        logic [3:0] e_tin, e_pin;
        e_rdy = 1'b1; e_uacc = 1'b0; e_inm = 1'b0; e_outm = 1'b1;
        e_done = 1'b0; e_err = 1'b0; e_bus = 1'b0;
        e_cm = 2'b00; e_tin = 4'd0; e_pin = 4'd0;
        m_pop = 1'b0;
        m_d = 0;
        m_lat = 1;
        if (exp_q.size() != 0) begin
            m_tr = exp_q[0];
            m_d = cyc - m_tr.acc;
            m_lat = isLong(m_tr.op) ? 3 : 1;
            e_rdy = 1'b0;
            if (m_d == m_lat) begin
                e_done = 1'b1;
                e_err = (m_tr.op == 3'd7);
            end else if (m_lat == 3 && (m_d == 1 || m_d == 2)) begin
                if (m_tr.op == 3'd1) begin
                    e_inm = 1'b1;
                    e_pin = m_tr.data;
                end else if (isAlu(m_tr.op)) begin
                    e_tin = m_tr.data;
                    e_cm = 2'(m_tr.op - 3'd2);
                end else begin
                    e_outm = 1'b0;
                    e_bus = (m_d == 2);
                end
                e_uacc = (m_d == 2) && (m_tr.op != 3'd6);
            end
        end
        m_exp = {e_rdy, e_uacc, e_inm, e_outm, e_cm, e_tin, e_pin, e_done, e_err, e_bus};
        m_act = {in_ready, uacc, inmode, outmode, cmode, tin, pin, done, err, bus_valid};
        checkOutput($sformatf("outputs{rdy,uacc,inm,outm,cm,tin,pin,done,err,bus} cyc %0d", cyc),
                    32'(m_act), 32'(m_exp));
        checkOutput($sformatf("flag_q cyc %0d", cyc), 32'(flag_q), 32'(fq_exp));
`ifdef ALU_SEQ_OPCNT_EN
        checkOutput($sformatf("op_cnt cyc %0d", cyc), 32'(op_cnt), 32'(cnt_exp));
`endif
        if (exp_q.size() != 0 && (done === 1'b1 || m_d >= m_lat)) begin
            m_pop = 1'b1;
            void'(exp_q.pop_front());
        end
        if (rst) begin
            fq_exp = 3'b000;
            cnt_exp = 0;
        end else if (m_pop) begin
            if (isAlu(m_tr.op)) fq_exp = m_tr.fq;
            if (isLong(m_tr.op) && cnt_exp < 255) cnt_exp++;
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Load, then add with carry out.
        applyStimulus(3'd1, 4'd5, 1'b0);
        waitIdle();
        applyStimulus(3'd1, 4'd9, 1'b0);
        applyStimulus(3'd2, 4'd9, 1'b0);
        waitIdle();
        checkOutput("flag_q after 9+9", 32'(flag_q), 32'(3'b100));

        // XOR of zero into zero, then an OUT transfer.
        applyStimulus(3'd1, 4'd0, 1'b0);
        applyStimulus(3'd5, 4'd0, 1'b0);
        waitIdle();
        checkOutput("flag_q after xor 0", 32'(flag_q), 32'(3'b011));
        applyStimulus(3'd6, 4'd7, 1'b0);
        waitIdle();

        // Illegal opcode and NOP: short path, flags untouched.
        applyStimulus(3'd7, 4'd3, 1'b0);
        waitIdle();
        checkOutput("flag_q after illegal", 32'(flag_q), 32'(3'b011));
        applyStimulus(3'd0, 4'd1, 1'b0);
        waitIdle();

        // Reset while IDLE with an instruction offered, then mid-EXEC reset.
        resetAfter(0);
        applyStimulus(3'd1, 4'd3, 1'b0);
        applyStimulus(3'd2, 4'd4, 1'b0);
        resetAfter(1);
        waitIdle();
        checkOutput("flag_q after mid-exec reset", 32'(flag_q), 32'(3'b000));

        // Random instruction stream with occasional resets in flight.
        for (int i = 0; i < 80; i++) begin
            bit keep;
            keep = 1'($urandom_range(0, 1));
            applyStimulus(3'($urandom_range(0, 7)), 4'($urandom), keep);
            if ($urandom_range(0, 9) == 0) begin
                resetAfter($urandom_range(0, 2));
            end else if (!keep) begin
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
            end
        end
        waitIdle();

        // Back-to-back instructions with in_valid held high throughout.
        for (int i = 0; i < 300; i++) begin
            applyStimulus(3'($urandom_range(1, 5)), 4'($urandom), i < 299);
        end
        waitIdle();
`ifdef ALU_SEQ_OPCNT_EN
        checkOutput("op_cnt saturated", 32'(op_cnt), 32'd255);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
